camera_frame_dma: RTL and testbench
===================================

# camera_frame_dma

Single-clock frame-capture DMA engine. It sits between an upstream pixel packer and the shared bus. Pixel words are buffered in an internal FIFO and written to memory as bus-master bursts of configurable length. It is controlled through a custom-instruction (CI) port and adds single-shot/continuous capture, ping-pong frame buffers, overflow accounting and bus-error abort.

## Interface
Parameters:
- customInstructionId, 8'd0, CI opcode matched against ciN
- fifoDepthLog2, 4, FIFO depth = 2^fifoDepthLog2 words (≥2)
- maxBurst, 16, maximum burst length in words (≤256, ≤ FIFO depth)

Ports:
- clock  in  1  system clock; all logic on posedge
- reset  in  1  asynchronous, active-low reset
- frameStart  in  1  one-cycle pulse, start of frame
- frameEnd  in  1  one-cycle pulse, end of frame (after last pixelValid)
- pixelValid  in  1  pixelWord valid this cycle
- pixelWord  in  32  packed pixel data
- ciStart, ciCke  in  1  CI handshake
- ciN  in  8  CI opcode
- ciValueA, ciValueB  in  32  CI operands
- ciResult  out  32  CI result; 0 when not selected
- ciDone  out  1  = ciStart & ciCke & (ciN == customInstructionId)
- requestBus  out  1  bus request
- busGrant  in  1  bus grant
- beginTransactionOut, endTransactionOut  out  1  transaction framing
- addressDataOut  out  32  address in INIT, data in BURST
- byteEnablesOut  out  4  4'hF with begin, else 0
- dataValidOut  out  1  data word valid
- burstSizeOut  out  8  burst length − 1 with begin, else 0
- busyIn, busErrorIn  in  1  slave busy / bus error

## Operation
- CI (ciValueA[2:0]); writes take effect from the next frameStart:
  - 0: read baseA.
  - 1: write baseA = {ciValueB[31:2],2'b0}.
  - 2: write baseB = {ciValueB[31:2],2'b0}.
  - 3: write burstLen = ciValueB[8:0], clamped to 1..maxBurst.
  - 4: write mode. ciValueB[1:0]: 01 = continuous, 10 = single shot, 00/11 = stop.
  - 5: read baseB.
  - 6: read status {overflowCount[15:0], 12'd0, error, activeBuf, capturing, frameDone}.
  - 7: read frameDone, then clear it. A set event in the same cycle wins.
- Arming: on frameStart, if mode ≠ stop and no frame is in progress:
  - capturing ← 1.
  - addr ← active base.
  - Otherwise frameStart is ignored.
- Push: pixelValid & capturing. If the FIFO is full and there is no pop this cycle, the word is dropped and overflowCount increments, saturating at 16'hFFFF. Words arriving while not capturing are discarded silently.
- frameEnd while capturing: capturing ← 0, flush ← 1.
- Burst trigger (IDLE): count ≥ burstLen → n = burstLen; else if flush & count > 0 → n = count.
- State machine:
  - IDLE → REQUEST on trigger; n is latched here.
  - REQUEST → INIT on busGrant.
  - INIT → BURST.
  - BURST → END when n words are sent and !busyIn.
  - BURST → ABORT on busErrorIn.
  - END → IDLE.
  - ABORT → IDLE.
- Data: each BURST cycle with !busyIn and words remaining pops one FIFO word and drives it with dataValidOut = 1, then addr += 4. While busyIn is high, the last data and dataValidOut are held.
- Frame completion: flush & count = 0 & state = IDLE. Effects:
  - frameDone ← 1, flush ← 0.
  - activeBuf toggles (see Configuration).
  - Single-shot mode → stop.
- ABORT:
  - endTransactionOut = 1.
  - FIFO cleared, capturing/flush ← 0, error ← 1, mode ← stop.
  - error is cleared by a mode write.

## Timing
- Reset values:
  - All bus outputs 0.
  - ciResult 0 (combinational), ciDone follows its inputs.
  - baseA/baseB 0, burstLen = maxBurst, mode stop, FIFO empty, counters 0, activeBuf 0, frameDone 0, error 0.
- CI is zero-latency (combinational result, ciDone in the same cycle).
- Bus outputs are registered:
  - beginTransactionOut, byteEnablesOut and burstSizeOut are valid the cycle after INIT.
  - endTransactionOut is asserted exactly one cycle after END or ABORT.
- Minimum latency from trigger to the first data word: 4 cycles with busGrant already high.
- FIFO allows simultaneous push and pop when full; both succeed and count is unchanged.
- frameEnd and frameStart in the same cycle: frameEnd is processed; frameStart is ignored.
- Reset mid-burst: all outputs drop to 0 asynchronously; there is no endTransactionOut.

## Configuration
- CAMERA_FRAME_DMA_DOUBLE_BUFFER_EN defined:
  - activeBuf toggles on each frame completion.
  - The arming base is baseB when activeBuf = 1, else baseA.
- Not defined:
  - activeBuf is fixed at 0 and always uses baseA.
  - baseB is write-ignored and reads 0.

## Test plan
- baseA = 0x1000, burstLen = 4, single shot; 10 words then frameEnd → bursts of 4, 4, 2 at 0x1000, 0x1010, 0x1020; burstSizeOut 3, 3, 1; frameDone = 1; mode returns to stop.
- Hold busGrant low, push FIFO depth + 3 words → overflowCount = 3; first FIFO-depth words written in order after grant.
- busyIn high 3 cycles mid-burst → data and dataValidOut held; no word lost or duplicated; addresses contiguous.
- busErrorIn at 2nd data word → endTransactionOut one cycle later; status error = 1, capturing = 0; further frameStart ignored until mode write.
- Double-buffer build, continuous mode, baseA = 0x2000, baseB = 0x8000, three frames → start addresses 0x2000, 0x8000, 0x2000.
- frameDone set and CI read 7 in the same cycle → returns previous value; frameDone remains 1.

Source files
------------

// File: rtl/camera_frame_dma.sv
// camera_frame_dma: frame-capture DMA engine. Pixel words are buffered in an
// internal FIFO and written to memory as bus-master bursts. It is configured
// and monitored through a custom-instruction port.
// Optional feature: define CAMERA_FRAME_DMA_DOUBLE_BUFFER_EN for ping-pong
// frame buffers (baseA/baseB alternate on each completed frame).
module camera_frame_dma #(
    parameter logic [7:0]  customInstructionId = 8'd0,
    parameter int unsigned fifoDepthLog2       = 4,
    parameter int unsigned maxBurst            = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frameStart,
    input  logic        frameEnd,
    input  logic        pixelValid,
    input  logic [31:0] pixelWord,
    input  logic        ciStart,
    input  logic        ciCke,
    input  logic [7:0]  ciN,
    input  logic [31:0] ciValueA,
    input  logic [31:0] ciValueB,
    output logic [31:0] ciResult,
    output logic        ciDone,
    output logic        requestBus,
    input  logic        busGrant,
    output logic        beginTransactionOut,
    output logic        endTransactionOut,
    output logic [31:0] addressDataOut,
    output logic [3:0]  byteEnablesOut,
    output logic        dataValidOut,
    output logic [7:0]  burstSizeOut,
    input  logic        busyIn,
    input  logic        busErrorIn
);

    localparam int unsigned DEPTH = 1 << fifoDepthLog2;
    localparam int unsigned PW    = fifoDepthLog2;
    localparam int unsigned CW    = fifoDepthLog2 + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_REQUEST, S_INIT, S_BURST, S_END, S_ABORT
    } state_t;

    // Burst length is kept within 1..maxBurst
    function automatic logic [8:0] clamp_len(input logic [8:0] v);
        if (v == 9'd0) return 9'd1;
        if (32'(v) > maxBurst) return 9'(maxBurst);
        return v;
    endfunction

    // Overflow counter saturates instead of wrapping
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t        state, state_next;
    logic [31:0]   base_a;
    logic [31:0]   base_b_rd;
    logic [31:0]   arm_base;
    logic [8:0]    len_cfg;
    logic [8:0]    burst_len;
    logic [1:0]    mode;
    logic [31:0]   addr;
    logic          capturing, flush, frame_done, error;
    logic          active_buf;
    logic [15:0]   overflow_count;
    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [8:0]    remaining, burst_n;
    logic          trigger;
    logic [8:0]    trig_len;
    logic          ci_sel;
    logic [2:0]    ci_op;
    logic          push_req, full, pop, push, overflow;
    logic          mode_on, arm, complete;
    logic [31:0]   status;
    logic          unused_bits;

    assign ci_sel      = ciStart & ciCke & (ciN == customInstructionId);
    assign ci_op       = ciValueA[2:0];
    assign ciDone      = ci_sel;
    assign unused_bits = ^ciValueA[31:3];

    assign push_req = pixelValid & capturing;
    assign full     = (count == CW'(DEPTH));
    assign pop      = (state == S_BURST) && !busyIn && !busErrorIn && (remaining != '0);
    assign push     = push_req && (!full || pop);
    assign overflow = push_req && full && !pop;

    assign mode_on  = (mode == 2'b01) || (mode == 2'b10);
    assign arm      = frameStart && !frameEnd && mode_on && !capturing && !flush;
    assign complete = flush && (count == '0) && (state == S_IDLE);
    assign status   = {overflow_count, 12'd0, error, active_buf, capturing, frame_done};

`ifdef CAMERA_FRAME_DMA_DOUBLE_BUFFER_EN
    logic [31:0] base_b;
    assign base_b_rd = base_b;
    assign arm_base  = active_buf ? base_b : base_a;

    // Ping-pong selector flips after every completed frame
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)        active_buf <= 1'b0;
        else if (complete) active_buf <= ~active_buf;
    end

    // Second buffer base, writable only in the double-buffer build
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                         base_b <= '0;
        else if (ci_sel && ci_op == 3'd2)   base_b <= {ciValueB[31:2], 2'b00};
    end
`else
    assign base_b_rd  = '0;
    assign arm_base   = base_a;
    assign active_buf = 1'b0;
`endif

    // CI readback, zero when the instruction is not addressed to this block
    always_comb begin
        ciResult = '0;
        if (ci_sel) begin
            case (ci_op)
                3'd0:    ciResult = base_a;
                3'd5:    ciResult = base_b_rd;
                3'd6:    ciResult = status;
                3'd7:    ciResult = {31'd0, frame_done};
                default: ciResult = '0;
            endcase
        end
    end

    // Configuration registers; values are sampled into the engine at arming
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            base_a  <= '0;
            len_cfg <= 9'(maxBurst);
        end else if (ci_sel) begin
            if (ci_op == 3'd1) base_a  <= {ciValueB[31:2], 2'b00};
            if (ci_op == 3'd3) len_cfg <= clamp_len(ciValueB[8:0]);
        end
    end

    // Frame control: arming, flush, completion, abort and mode handling
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            capturing  <= 1'b0;
            flush      <= 1'b0;
            frame_done <= 1'b0;
            error      <= 1'b0;
            mode       <= 2'b00;
            addr       <= '0;
            burst_len  <= 9'(maxBurst);
        end else begin
            if (pop) addr <= addr + 32'd4;
            if (frameEnd && capturing) begin
                capturing <= 1'b0;
                flush     <= 1'b1;
            end else if (arm) begin
                capturing <= 1'b1;
                addr      <= arm_base;
                burst_len <= len_cfg;
            end
            // a completion in the same cycle as a read-and-clear keeps the flag set
            if (complete) begin
                flush      <= 1'b0;
                frame_done <= 1'b1;
                if (mode == 2'b10) mode <= 2'b00;
            end else if (ci_sel && ci_op == 3'd7) begin
                frame_done <= 1'b0;
            end
            if (ci_sel && ci_op == 3'd4) begin
                mode  <= ciValueB[1:0];
                error <= 1'b0;
            end
            if (state == S_ABORT) begin
                capturing <= 1'b0;
                flush     <= 1'b0;
                error     <= 1'b1;
                mode      <= 2'b00;
            end
        end
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= pixelWord;
    end

    // FIFO pointers and occupancy; an abort discards everything buffered
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (state == S_ABORT) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    // Dropped-word accounting
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)        overflow_count <= '0;
        else if (overflow) overflow_count <= sat_inc(overflow_count);
    end

    // Burst length is latched when leaving IDLE and counted down per word
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
            burst_n   <= '0;
        end else if (state == S_IDLE && trigger) begin
            remaining <= trig_len;
            burst_n   <= trig_len;
        end else if (pop) begin
            remaining <= remaining - 9'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // FSM next state plus burst trigger evaluation
    always_comb begin
        state_next = state;
        trigger    = 1'b0;
        trig_len   = burst_len;
        if (32'(count) >= 32'(burst_len)) begin
            trigger  = 1'b1;
            trig_len = burst_len;
        end else if (flush && count != '0) begin
            trigger  = 1'b1;
            trig_len = 9'(count);
        end
        case (state)
            S_IDLE:    if (trigger) state_next = S_REQUEST;
            S_REQUEST: if (busGrant) state_next = S_INIT;
            S_INIT:    state_next = S_BURST;
            S_BURST: begin
                if (busErrorIn)                         state_next = S_ABORT;
                else if (remaining == '0 && !busyIn)    state_next = S_END;
            end
            S_END:     state_next = S_IDLE;
            S_ABORT:   state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Registered bus outputs; data and valid hold while the slave is busy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            requestBus          <= 1'b0;
            beginTransactionOut <= 1'b0;
            endTransactionOut   <= 1'b0;
            addressDataOut      <= '0;
            byteEnablesOut      <= '0;
            dataValidOut        <= 1'b0;
            burstSizeOut        <= '0;
        end else begin
            requestBus          <= (state_next == S_REQUEST) || (state_next == S_INIT) ||
                                   (state_next == S_BURST);
            beginTransactionOut <= (state == S_INIT);
            byteEnablesOut      <= (state == S_INIT) ? 4'hF : 4'h0;
            burstSizeOut        <= (state == S_INIT) ? 8'(burst_n - 9'd1) : 8'd0;
            endTransactionOut   <= (state == S_END) || (state == S_ABORT);
            case (state)
                S_INIT: begin
                    addressDataOut <= addr;
                    dataValidOut   <= 1'b0;
                end
                S_BURST: begin
                    if (busErrorIn) begin
                        addressDataOut <= '0;
                        dataValidOut   <= 1'b0;
                    end else if (pop) begin
                        addressDataOut <= mem[rd_ptr];
                        dataValidOut   <= 1'b1;
                    end else if (!busyIn) begin
                        addressDataOut <= '0;
                        dataValidOut   <= 1'b0;
                    end
                end
                default: begin
                    addressDataOut <= '0;
                    dataValidOut   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_camera_frame_dma.sv
// Testbench for camera_frame_dma: CI vector table, then frame sequences with a
// scoreboard of expected bursts and data words checked by a bus monitor.
module tb_camera_frame_dma;

    logic        clock = 1'b0;
    logic        reset;
    logic        frameStart, frameEnd, pixelValid;
    logic [31:0] pixelWord;
    logic        ciStart, ciCke;
    logic [7:0]  ciN;
    logic [31:0] ciValueA, ciValueB;
    logic [31:0] ciResult;
    logic        ciDone;
    logic        requestBus, busGrant;
    logic        beginTransactionOut, endTransactionOut;
    logic [31:0] addressDataOut;
    logic [3:0]  byteEnablesOut;
    logic        dataValidOut;
    logic [7:0]  burstSizeOut;
    logic        busyIn, busErrorIn;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  size;
    } burst_t;

    typedef struct {
        logic [7:0]  n;
        logic [31:0] a;
        logic [31:0] b;
        logic        st;
        logic        cke;
        logic        done;
        logic [31:0] res;
    } ci_vec_t;

    logic [31:0] exp_data[$];
    burst_t      exp_burst[$];

    camera_frame_dma dut (
        .clock(clock), .reset(reset),
        .frameStart(frameStart), .frameEnd(frameEnd),
        .pixelValid(pixelValid), .pixelWord(pixelWord),
        .ciStart(ciStart), .ciCke(ciCke), .ciN(ciN),
        .ciValueA(ciValueA), .ciValueB(ciValueB),
        .ciResult(ciResult), .ciDone(ciDone),
        .requestBus(requestBus), .busGrant(busGrant),
        .beginTransactionOut(beginTransactionOut), .endTransactionOut(endTransactionOut),
        .addressDataOut(addressDataOut), .byteEnablesOut(byteEnablesOut),
        .dataValidOut(dataValidOut), .burstSizeOut(burstSizeOut),
        .busyIn(busyIn), .busErrorIn(busErrorIn)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Bus monitor: burst headers and accepted data words against the scoreboard
    always @(negedge clock) begin
        burst_t b;
        if (reset === 1'b1) begin
            if (beginTransactionOut) begin
                if (exp_burst.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_begin: got addr 0x%08h with no burst expected", addressDataOut);
                end else begin
                    b = exp_burst.pop_front();
                    check("burst_addr", addressDataOut, b.addr);
                    check("burst_size", {24'd0, burstSizeOut}, {24'd0, b.size});
                    check("byte_en", {28'd0, byteEnablesOut}, 32'hF);
                end
            end
            if (dataValidOut && !busyIn) begin
                if (exp_data.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_data: got 0x%08h with no word expected", addressDataOut);
                end else begin
                    check("data_word", addressDataOut, exp_data.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic ci_write(input logic [2:0] op, input logic [31:0] val);
        ciStart = 1'b1; ciCke = 1'b1; ciN = 8'd0;
        ciValueA = {29'd0, op}; ciValueB = val;
        step();
        ciStart = 1'b0; ciCke = 1'b0;
    endtask

    task automatic ci_read(input logic [2:0] op, output logic [31:0] res);
        ciStart = 1'b1; ciCke = 1'b1; ciN = 8'd0;
        ciValueA = {29'd0, op}; ciValueB = '0;
        #1;
        res = ciResult;
        step();
        ciStart = 1'b0; ciCke = 1'b0;
    endtask

    task automatic pulse_start();
        frameStart = 1'b1;
        step();
        frameStart = 1'b0;
    endtask

    // Drive one frame; the first 'keep' words are expected on the bus
    task automatic frame(input int n, input bit send_end, input int keep);
        pulse_start();
        for (int i = 0; i < n; i++) begin
            pixelValid = 1'b1;
            pixelWord  = $urandom;
            if (i < keep) exp_data.push_back(pixelWord);
            step();
        end
        pixelValid = 1'b0;
        if (send_end) begin
            frameEnd = 1'b1;
            step();
            frameEnd = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        logic [31:0] r;
        bit got;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            ci_read(3'd6, r);
            got = r[0];
        end
        check(name, {31'd0, got}, 32'd1);
    endtask

    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock);
            seen = dataValidOut;
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic push_burst(input logic [31:0] a, input logic [7:0] s);
        burst_t b;
        b.addr = a;
        b.size = s;
        exp_burst.push_back(b);
    endtask

    initial begin
        ci_vec_t     vec[11];
        logic [31:0] r, held_d, base_b_exp;

`ifdef CAMERA_FRAME_DMA_DOUBLE_BUFFER_EN
        base_b_exp = 32'h8000;
`else
        base_b_exp = 32'h0;
`endif
        vec[0]  = '{8'd0, 32'd6, 32'h0,    1'b1, 1'b1, 1'b1, 32'h0};
        vec[1]  = '{8'd1, 32'd0, 32'h0,    1'b1, 1'b1, 1'b0, 32'h0};
        vec[2]  = '{8'd0, 32'd0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0};
        vec[3]  = '{8'd0, 32'd1, 32'h1003, 1'b1, 1'b1, 1'b1, 32'h0};
        vec[4]  = '{8'd0, 32'd0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h1000};
        vec[5]  = '{8'd0, 32'd2, 32'h8003, 1'b1, 1'b1, 1'b1, 32'h0};
        vec[6]  = '{8'd0, 32'd5, 32'h0,    1'b1, 1'b1, 1'b1, base_b_exp};
        vec[7]  = '{8'd0, 32'd7, 32'h0,    1'b1, 1'b1, 1'b1, 32'h0};
        vec[8]  = '{8'd0, 32'd3, 32'd4,    1'b1, 1'b1, 1'b1, 32'h0};
        vec[9]  = '{8'd0, 32'd4, 32'd2,    1'b1, 1'b1, 1'b1, 32'h0};
        vec[10] = '{8'd0, 32'd6, 32'h0,    1'b1, 1'b1, 1'b1, 32'h0};

        reset = 1'b0;
        frameStart = 0; frameEnd = 0; pixelValid = 0; pixelWord = '0;
        ciStart = 0; ciCke = 0; ciN = 8'd0; ciValueA = '0; ciValueB = '0;
        busGrant = 0; busyIn = 0; busErrorIn = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_request", {31'd0, requestBus}, 32'd0);
        check("rst_begin", {31'd0, beginTransactionOut}, 32'd0);
        check("rst_end", {31'd0, endTransactionOut}, 32'd0);
        check("rst_addr", addressDataOut, 32'd0);
        check("rst_be", {28'd0, byteEnablesOut}, 32'd0);
        check("rst_valid", {31'd0, dataValidOut}, 32'd0);
        check("rst_bsize", {24'd0, burstSizeOut}, 32'd0);
        check("rst_ciresult", ciResult, 32'd0);
        check("rst_cidone", {31'd0, ciDone}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        step();

        // CI vector table
        for (int i = 0; i < 11; i++) begin
            ciN = vec[i].n; ciValueA = vec[i].a; ciValueB = vec[i].b;
            ciStart = vec[i].st; ciCke = vec[i].cke;
            #1;
            check($sformatf("ci_done[%0d]", i), {31'd0, ciDone}, {31'd0, vec[i].done});
            check($sformatf("ci_result[%0d]", i), ciResult, vec[i].res);
            step();
            ciStart = 1'b0; ciCke = 1'b0; ciN = 8'd0;
        end
`ifdef CAMERA_FRAME_DMA_DOUBLE_BUFFER_EN
        ci_write(3'd2, 32'h1000);
`endif

        // Single shot, 10 words in bursts of 4
        busGrant = 1'b1;
        push_burst(32'h1000, 8'd3);
        push_burst(32'h1010, 8'd3);
        push_burst(32'h1020, 8'd1);
        frame(10, 1'b1, 10);
        wait_done("t1_frame_done");
        ci_read(3'd6, r);
        check("t1_status", r & 32'hFFFF_000B, 32'h1);
        pulse_start();
        ci_read(3'd6, r);
        check("t1_mode_stopped", {31'd0, r[1]}, 32'd0);
        ci_read(3'd7, r);
        check("t1_done_read", r, 32'd1);
        ci_read(3'd7, r);
        check("t1_done_cleared", r, 32'd0);

        // Burst length 0 clamps to single-word bursts
        ci_write(3'd3, 32'd0);
        ci_write(3'd4, 32'd2);
        push_burst(32'h1000, 8'd0);
        push_burst(32'h1004, 8'd0);
        push_burst(32'h1008, 8'd0);
        frame(3, 1'b1, 3);
        wait_done("clamp_frame_done");
        ci_read(3'd7, r);

        // Overflow with grant held low; burst length 300 clamps to 16
        ci_write(3'd3, 32'd300);
        ci_write(3'd4, 32'd2);
        busGrant = 1'b0;
        push_burst(32'h1000, 8'd15);
        frame(19, 1'b1, 16);
        repeat (3) step();
        check("ovf_request_held", {31'd0, requestBus}, 32'd1);
        ci_read(3'd6, r);
        check("ovf_count", {16'd0, r[31:16]}, 32'd3);
        busGrant = 1'b1;
        wait_done("ovf_frame_done");
        ci_read(3'd7, r);

        // Slave busy for 3 cycles in the middle of a burst
        ci_write(3'd3, 32'd8);
        ci_write(3'd4, 32'd2);
        busGrant = 1'b0;
        push_burst(32'h1000, 8'd7);
        frame(8, 1'b1, 8);
        busGrant = 1'b1;
        wait_valid("busy_first_word");
        step();
        busyIn = 1'b1;
        @(negedge clock);
        held_d = addressDataOut;
        step();
        step();
        @(negedge clock);
        check("busy_data_held", addressDataOut, held_d);
        check("busy_valid_held", {31'd0, dataValidOut}, 32'd1);
        step();
        busyIn = 1'b0;
        wait_done("busy_frame_done");
        check("busy_no_loss", exp_data.size(), 32'd0);
        ci_read(3'd7, r);

        // Bus error on the second data word
        ci_write(3'd3, 32'd4);
        ci_write(3'd4, 32'd2);
        busGrant = 1'b0;
        push_burst(32'h1000, 8'd3);
        frame(4, 1'b0, 4);
        busGrant = 1'b1;
        wait_valid("err_first_word");
        step();
        busErrorIn = 1'b1;
        @(negedge clock);
        check("err_end_at_error", {31'd0, endTransactionOut}, 32'd0);
        step();
        busErrorIn = 1'b0;
        @(negedge clock);
        check("err_end_in_abort", {31'd0, endTransactionOut}, 32'd0);
        step();
        @(negedge clock);
        check("err_end_after_abort", {31'd0, endTransactionOut}, 32'd1);
        exp_data.delete();
        step();
        ci_read(3'd6, r);
        check("err_status", r & 32'h0000_000B, 32'h8);
        pulse_start();
        ci_read(3'd6, r);
        check("err_start_ignored", {31'd0, r[1]}, 32'd0);
        ci_write(3'd4, 32'd2);
        ci_read(3'd6, r);
        check("err_cleared", {31'd0, r[3]}, 32'd0);
        pulse_start();
        ci_read(3'd6, r);
        check("err_rearmed", {31'd0, r[1]}, 32'd1);
        frameEnd = 1'b1;
        step();
        frameEnd = 1'b0;
        wait_done("err_empty_frame_done");
        ci_read(3'd7, r);

        // frameDone set in the same cycle as a read-and-clear
        ci_write(3'd4, 32'd2);
        frameStart = 1'b1;
        step();
        frameStart = 1'b0;
        frameEnd = 1'b1;
        step();
        frameEnd = 1'b0;
        ci_read(3'd7, r);
        check("race_read_prev", r, 32'd0);
        ci_read(3'd6, r);
        check("race_done_kept", {31'd0, r[0]}, 32'd1);
        ci_read(3'd7, r);

        // Asynchronous reset in the middle of a burst
        ci_write(3'd3, 32'd4);
        ci_write(3'd4, 32'd2);
        push_burst(32'h1000, 8'd3);
        frame(4, 1'b0, 4);
        wait_valid("rst_mid_first_word");
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, dataValidOut}, 32'd0);
        check("rst_mid_request", {31'd0, requestBus}, 32'd0);
        check("rst_mid_data", addressDataOut, 32'd0);
        exp_data.delete();
        exp_burst.delete();
        step();
        reset = 1'b1;
        step();

        // Continuous mode over three frames
        ci_write(3'd1, 32'h2000);
        ci_write(3'd2, 32'h8000);
        ci_write(3'd3, 32'd4);
        ci_write(3'd4, 32'd1);
        for (int f = 0; f < 3; f++) begin
`ifdef CAMERA_FRAME_DMA_DOUBLE_BUFFER_EN
            push_burst((f % 2 == 1) ? 32'h8000 : 32'h2000, 8'd1);
`else
            push_burst(32'h2000, 8'd1);
`endif
            frame(2, 1'b1, 2);
            wait_done($sformatf("cont_frame_done[%0d]", f));
            ci_read(3'd7, r);
        end
        ci_write(3'd4, 32'd0);
        repeat (3) step();

        check("sb_data_empty", exp_data.size(), 32'd0);
        check("sb_burst_empty", exp_burst.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
